sprite_row_scheduler: RTL
=========================

Name: sprite_row_scheduler

Overview:
Per-scanline fetch controller for the shared tank sprite ROMs (four 32x32 direction images, 24-bit RGB, 1-cycle read latency). It starts at the beginning of horizontal blank. For each enabled tank that intersects the next scanline, it reads that tank's 32-pixel sprite row from the ROM and writes it into an external per-tank line buffer. The colour mapper then reads only the line buffers during active video. This removes the per-pixel sprite ROM address mux and the read-latency hazard between tanks.

Parameters:
NUM_SPRITES, 2, number of tanks served (index 0 has highest fetch priority)
SPRITE_W, 32, sprite width in pixels (power of 2)
SPRITE_H, 32, sprite height in lines (power of 2)
ROM_LAT, 1, ROM read latency in clocks (1..3)

Ports:
Clk  in  1  system clock
Reset_n  in  1  asynchronous, active-low reset
line_start  in  1  one-cycle pulse at start of hblank
next_y  in  10  scanline to fetch; sampled with line_start
spr_x  in  10*NUM_SPRITES  tank X positions, packed; passed through only
spr_y  in  10*NUM_SPRITES  tank top-left Y, packed
spr_dir  in  3*NUM_SPRITES  tank direction, packed: 001 up, 010 right, 011 left, 100 down
spr_en  in  NUM_SPRITES  tank alive/visible
rom_rd  out  1  ROM read strobe
rom_sel  out  2  ROM select: 0 up, 1 right, 2 left, 3 down
rom_addr  out  10  {row[4:0], col[4:0]}
rom_data  in  24  ROM data, valid ROM_LAT cycles after rom_rd
buf_we  out  1  line buffer write enable
buf_sprite  out  $clog2(NUM_SPRITES)  target buffer
buf_col  out  5  pixel column 0..31
buf_data  out  24  pixel RGB
buf_opaque  out  1  pixel-not-transparent flag
buf_hit  out  NUM_SPRITES  per tank: row valid for the fetched line
busy  out  1  FSM not in IDLE
done  out  1  one-cycle pulse when line fetch completes
overrun  out  1  sticky: line_start arrived while busy

Behaviour:
- Reset (async, Reset_n=0): all outputs 0, FSM to IDLE, in-flight reads discarded, overrun cleared.
- FSM states: IDLE, SCAN, FETCH, DRAIN, DONE.
- IDLE, on line_start: latch next_y; snapshot spr_y, spr_dir and spr_en; clear buf_hit; set i=0; go to SCAN.
- SCAN (1 cycle per tank): tank i hits when all hold:
  - spr_en[i]=1;
  - spr_dir[i] is in {001..100};
  - next_y >= spr_y[i] (11-bit unsigned compare, no wrap);
  - next_y - spr_y[i] < SPRITE_H.
- SCAN outcomes:
  - Hit: set buf_hit[i]; row = (next_y - spr_y[i])[4:0]; col=0; go to FETCH.
  - Miss: i++.
  - After the last tank is scanned: go to DONE.
- FETCH:
  - Each cycle: rom_rd=1, rom_sel from the snapshotted dir, rom_addr={row,col}, col++.
  - After col=31 is issued: go to DRAIN.
- Write pipeline: ROM_LAT-deep shift of {valid, sprite, col}. buf_we, buf_sprite and buf_col lag the matching rom_rd by exactly ROM_LAT cycles. buf_data=rom_data in that cycle.
- DRAIN: wait ROM_LAT cycles until the pipeline is empty. Then i++ and go to SCAN, or go to DONE if i was the last tank.
- DONE: done=1 for one cycle, then go to IDLE. buf_hit holds until the next line_start.
- Worst case: NUM_SPRITES*(SPRITE_W+ROM_LAT+1)+2 cycles, which is 70 for the defaults. This is within the 160-clock hblank.
- line_start while busy:
  - set overrun (cleared only by reset);
  - abort the current fetch: pipeline flushed, no further buf_we from the old line;
  - restart in SCAN with the new next_y.
- Snapshot isolation: spr_* changes during a fetch do not affect the line in progress.
- Unused spr_x is allowed; it is kept in the interface for the colour mapper.

Optional Feature:
TRANSPARENT_KEY_EN
- Defined: buf_opaque = (rom_data != 24'hFF0000), registered alongside buf_data.
- Undefined: buf_opaque is held at 1 whenever buf_we=1, and 0 otherwise.

Test Plan:
- Reset: assert Reset_n=0 mid-FETCH -> all outputs 0 immediately. After release, no buf_we until the next line_start.
- Single hit: tank0 y=100, dir=001, en=1; tank1 en=0; line_start with next_y=100 ->
  - rom_sel=0;
  - 32 consecutive rom_rd with addr 0..31;
  - buf_we cols 0..31 lagging by 1 cycle;
  - buf_hit=01;
  - done 36 cycles after line_start.
- Row boundaries: next_y=131 -> addr 992..1023. next_y=132 -> no rom_rd, buf_hit=00, done within 4 cycles.
- Two hits: tank0 y=50 dir=010, tank1 y=60 dir=100, next_y=70 ->
  - tank0 fetched first: rom_sel=1, addr 640..671;
  - then tank1: rom_sel=3, addr 320..351, buf_sprite=1;
  - buf_hit=11.
- Invalid and wrap cases: tank0 dir=000 -> skipped. spr_y=470, next_y=5 -> no hit (no wrap).
- Overrun: second line_start (next_y=101) at col 10 of a fetch ->
  - overrun=1;
  - no old-line writes after a 1-cycle flush;
  - full fetch of row 1 (addr 32..63).
  - With TRANSPARENT_KEY_EN: ROM word FF0000 -> buf_opaque=0.

Source files
------------

// File: rtl/sprite_row_scheduler.sv
// Per-scanline sprite row fetcher: copies each hit tank's sprite row from the shared ROM into its line buffer during hblank.
// Optional TRANSPARENT_KEY_EN macro: derive buf_opaque from the FF0000 colour key instead of forcing it high.
module sprite_row_scheduler #(
    parameter int NUM_SPRITES = 2,
    parameter int SPRITE_W    = 32,
    parameter int SPRITE_H    = 32,
    parameter int ROM_LAT     = 1
) (
    input  logic                                              Clk,
    input  logic                                              Reset_n,
    input  logic                                              line_start,
    input  logic [9:0]                                        next_y,
    input  logic [10*NUM_SPRITES-1:0]                         spr_x,
    input  logic [10*NUM_SPRITES-1:0]                         spr_y,
    input  logic [3*NUM_SPRITES-1:0]                          spr_dir,
    input  logic [NUM_SPRITES-1:0]                            spr_en,
    output logic                                              rom_rd,
    output logic [1:0]                                        rom_sel,
    output logic [$clog2(SPRITE_H)+$clog2(SPRITE_W)-1:0]      rom_addr,
    input  logic [23:0]                                       rom_data,
    output logic                                              buf_we,
    output logic [((NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1)-1:0] buf_sprite,
    output logic [$clog2(SPRITE_W)-1:0]                       buf_col,
    output logic [23:0]                                       buf_data,
    output logic                                              buf_opaque,
    output logic [NUM_SPRITES-1:0]                            buf_hit,
    output logic                                              busy,
    output logic                                              done,
    output logic                                              overrun
);

    localparam int CW = $clog2(SPRITE_W);
    localparam int RW = $clog2(SPRITE_H);
    localparam int IW = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;
    localparam int DW = (ROM_LAT > 1) ? $clog2(ROM_LAT) : 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SCAN  = 3'd1,
        S_FETCH = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    function automatic logic [1:0] dir_to_sel(input logic [2:0] dir);
        case (dir)
            3'd1:    return 2'd0;
            3'd2:    return 2'd1;
            3'd3:    return 2'd2;
            3'd4:    return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

    state_t                    state_q, state_d;
    logic [IW-1:0]             idx_q, idx_d;
    logic [RW-1:0]             row_q, row_d;
    logic [CW-1:0]             col_q, col_d;
    logic [9:0]                y_q, y_d;
    logic [10*NUM_SPRITES-1:0] sy_q, sy_d;
    logic [3*NUM_SPRITES-1:0]  sdir_q, sdir_d;
    logic [NUM_SPRITES-1:0]    sen_q, sen_d;
    logic [NUM_SPRITES-1:0]    hit_q, hit_d;
    logic [DW-1:0]             drain_q, drain_d;
    logic                      overrun_q, overrun_d;
    logic                      rom_rd_q, rom_rd_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;
    logic [1:0]                sel_q, sel_d;
    logic [RW+CW-1:0]          addr_q, addr_d;
    logic [ROM_LAT-1:0]        pv_q, pv_d;
    logic [IW-1:0]             pspr_q [ROM_LAT];
    logic [IW-1:0]             pspr_d [ROM_LAT];
    logic [CW-1:0]             pcol_q [ROM_LAT];
    logic [CW-1:0]             pcol_d [ROM_LAT];

    logic [9:0]  cur_y_s;
    logic [2:0]  cur_dir_s;
    logic        cur_en_s;
    logic [10:0] diff_s;
    logic        cur_hit_s;
    logic        last_s;
    logic        unused_s;

    // Hit test for the tank currently being scanned, on the snapshotted attributes.
    always_comb begin
        cur_y_s   = sy_q[10*int'(idx_q) +: 10];
        cur_dir_s = sdir_q[3*int'(idx_q) +: 3];
        cur_en_s  = sen_q[idx_q];
        diff_s    = {1'b0, y_q} - {1'b0, cur_y_s};
        cur_hit_s = cur_en_s && (cur_dir_s >= 3'd1) && (cur_dir_s <= 3'd4) &&
                    ({1'b0, y_q} >= {1'b0, cur_y_s}) && (diff_s < 11'(SPRITE_H));
        last_s    = (int'(idx_q) == NUM_SPRITES - 1);
    end

    // Next-state, datapath and write-pipeline logic.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        row_d     = row_q;
        col_d     = col_q;
        y_d       = y_q;
        sy_d      = sy_q;
        sdir_d    = sdir_q;
        sen_d     = sen_q;
        hit_d     = hit_q;
        drain_d   = drain_q;
        overrun_d = overrun_q;
        rom_rd_d  = 1'b0;
        sel_d     = sel_q;
        addr_d    = addr_q;
        done_d    = 1'b0;
        pv_d      = '0;
        pv_d[0]   = rom_rd_q;
        pspr_d[0] = idx_q;
        pcol_d[0] = addr_q[CW-1:0];
        for (int k = 1; k < ROM_LAT; k++) begin
            pv_d[k]   = pv_q[k-1];
            pspr_d[k] = pspr_q[k-1];
            pcol_d[k] = pcol_q[k-1];
        end

        if (line_start) begin
            // A new line always wins; anything in flight belongs to the stale line.
            if (state_q != S_IDLE) begin
                overrun_d = 1'b1;
            end else begin
                overrun_d = overrun_q;
            end
            y_d     = next_y;
            sy_d    = spr_y;
            sdir_d  = spr_dir;
            sen_d   = spr_en;
            hit_d   = '0;
            idx_d   = '0;
            col_d   = '0;
            drain_d = '0;
            pv_d    = '0;
            state_d = S_SCAN;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d = S_IDLE;
                end
                S_SCAN: begin
                    if (cur_hit_s) begin
                        hit_d[idx_q] = 1'b1;
                        row_d        = diff_s[RW-1:0];
                        col_d        = '0;
                        sel_d        = dir_to_sel(cur_dir_s);
                        addr_d       = {diff_s[RW-1:0], {CW{1'b0}}};
                        rom_rd_d     = 1'b1;
                        state_d      = S_FETCH;
                    end else if (last_s) begin
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end
                S_FETCH: begin
                    if (col_q == {CW{1'b1}}) begin
                        drain_d = '0;
                        state_d = S_DRAIN;
                    end else begin
                        col_d    = col_q + CW'(1);
                        addr_d   = {row_q, col_q + CW'(1)};
                        rom_rd_d = 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (drain_q == DW'(ROM_LAT - 1)) begin
                        if (last_s) begin
                            done_d  = 1'b1;
                            state_d = S_DONE;
                        end else begin
                            idx_d   = idx_q + IW'(1);
                            state_d = S_SCAN;
                        end
                    end else begin
                        drain_d = drain_q + DW'(1);
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
        busy_d = (state_d != S_IDLE);
    end

    // State and output registers.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            row_q     <= '0;
            col_q     <= '0;
            y_q       <= '0;
            sy_q      <= '0;
            sdir_q    <= '0;
            sen_q     <= '0;
            hit_q     <= '0;
            drain_q   <= '0;
            overrun_q <= 1'b0;
            rom_rd_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            sel_q     <= 2'd0;
            addr_q    <= '0;
            pv_q      <= '0;
            for (int k = 0; k < ROM_LAT; k++) begin
                pspr_q[k] <= '0;
                pcol_q[k] <= '0;
            end
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            row_q     <= row_d;
            col_q     <= col_d;
            y_q       <= y_d;
            sy_q      <= sy_d;
            sdir_q    <= sdir_d;
            sen_q     <= sen_d;
            hit_q     <= hit_d;
            drain_q   <= drain_d;
            overrun_q <= overrun_d;
            rom_rd_q  <= rom_rd_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            sel_q     <= sel_d;
            addr_q    <= addr_d;
            pv_q      <= pv_d;
            for (int k = 0; k < ROM_LAT; k++) begin
                pspr_q[k] <= pspr_d[k];
                pcol_q[k] <= pcol_d[k];
            end
        end
    end

    assign rom_rd     = rom_rd_q;
    assign rom_sel    = sel_q;
    assign rom_addr   = addr_q;
    assign buf_we     = pv_q[ROM_LAT-1];
    assign buf_sprite = pspr_q[ROM_LAT-1];
    assign buf_col    = pcol_q[ROM_LAT-1];
    // ROM data arrives in the write cycle itself, so it is gated rather than re-registered.
    assign buf_data   = buf_we ? rom_data : 24'h000000;
`ifdef TRANSPARENT_KEY_EN
    assign buf_opaque = buf_we && (rom_data != 24'hFF0000);
`else
    assign buf_opaque = buf_we;
`endif
    assign buf_hit    = hit_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign overrun    = overrun_q;

    // spr_x only travels alongside the other sprite fields for the colour mapper.
    assign unused_s   = ^spr_x;

endmodule
